// File: rtl/cache_pkg.sv
// Shared definitions for the backing-store controller: state encoding, default geometry.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
// Optional feature macro used by importers: MEM_STATS_EN (read/write completion counters).
package cache_pkg;

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_RD_WAIT = 2'b01;
    localparam logic [1:0] ST_WR_WAIT = 2'b10;
    localparam logic [1:0] ST_DONE    = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        RD_WAIT = ST_RD_WAIT,
        WR_WAIT = ST_WR_WAIT,
        DONE    = ST_DONE
    } state_t;

    localparam int DEF_ADDR_W      = 10;
    localparam int DEF_DATA_W      = 32;
    localparam int DEF_BLOCK_WORDS = 4;
    localparam int DEF_LATENCY     = 4;
    localparam int OFFSET_W        = $clog2(DEF_BLOCK_WORDS);
    localparam int STAT_W          = 16;

endpackage

// File: rtl/main_memory_ctrl_if.sv
// Request/response bundle between the cache controller and the backing store.
// Latency: n/a (wiring only).
// Backpressure: requester holds an enable until the one-cycle ready pulse.
// Ports: ReadEnable/WriteEnable/addr/wr_data (requester -> store),
//        ready/rd_block/busy and, with MEM_STATS_EN, rd_count/wr_count (store -> requester).
interface main_memory_ctrl_if
    import cache_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int BLOCK_WORDS = DEF_BLOCK_WORDS
);
    logic                          ReadEnable;
    logic                          WriteEnable;
    logic [ADDR_W-1:0]             addr;
    logic [DATA_W-1:0]             wr_data;
    logic                          ready;
    logic [BLOCK_WORDS*DATA_W-1:0] rd_block;
    logic                          busy;
`ifdef MEM_STATS_EN
    logic [STAT_W-1:0]             rd_count;
    logic [STAT_W-1:0]             wr_count;
`endif

    modport master (
        output ReadEnable, WriteEnable, addr, wr_data,
`ifdef MEM_STATS_EN
        input  rd_count, wr_count,
`endif
        input  ready, rd_block, busy
    );

    modport slave (
        input  ReadEnable, WriteEnable, addr, wr_data,
`ifdef MEM_STATS_EN
        output rd_count, wr_count,
`endif
        output ready, rd_block, busy
    );
endinterface

// File: rtl/main_memory_ctrl_mem_array.sv
// Word-addressed storage: synchronous single-word write, combinational whole-block read.
// Latency: write lands on the clock edge; block read is same-cycle.
// Backpressure: none, always accepts.
// Ports: clk, wr_en/wr_addr/wr_data (write side), rd_base -> rd_block (read side).
module mem_array
    import cache_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int BLOCK_WORDS = DEF_BLOCK_WORDS
) (
    input  logic                          clk,
    input  logic                          wr_en,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic [ADDR_W-1:0]             rd_base,
    output logic [BLOCK_WORDS*DATA_W-1:0] rd_block
);
    // Contents are deliberately not reset.
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // rd_base is block aligned, so OR-ing the word index never carries out of the block.
    always_comb begin
        rd_block = '0;
        for (int i = 0; i < BLOCK_WORDS; i++) begin
            rd_block[i*DATA_W +: DATA_W] = mem[rd_base | ADDR_W'(i)];
        end
    end
endmodule

// File: rtl/main_memory_ctrl.sv
// Backing store behind the write-through cache: block fills and word writes with fixed latency.
// Latency: accept at edge N -> ready high during the cycle after edge N+LATENCY.
// Backpressure: one request at a time; busy high outside IDLE, enables ignored until IDLE.
// Ports: clk, rst (async active-low), bus (slave side of main_memory_ctrl_if).
// MEM_STATS_EN adds saturating 16-bit rd_count/wr_count completion counters.
module main_memory_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int BLOCK_WORDS = DEF_BLOCK_WORDS,
    parameter int LATENCY     = DEF_LATENCY
) (
    input  logic              clk,
    input  logic              rst,
    main_memory_ctrl_if.slave bus
);
    localparam int              CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(BLOCK_WORDS - 1);

    state_t                        state, state_nxt;
    logic [CNT_W-1:0]              cnt, cnt_nxt;
    logic [ADDR_W-1:0]             req_addr;
    logic [DATA_W-1:0]             req_data;
    logic                          load_wr, load_rd;
    logic                          rd_fire, wr_fire;
    logic [BLOCK_WORDS*DATA_W-1:0] arr_block;

    mem_array #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .BLOCK_WORDS (BLOCK_WORDS)
    ) u_mem (
        .clk      (clk),
        .wr_en    (wr_fire),
        .wr_addr  (req_addr),
        .wr_data  (req_data),
        .rd_base  (req_addr),
        .rd_block (arr_block)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load_wr   = 1'b0;
        load_rd   = 1'b0;
        rd_fire   = 1'b0;
        wr_fire   = 1'b0;
        case (state)
            IDLE: begin
                // Write has priority; a simultaneous read is dropped, not queued.
                if (bus.WriteEnable) begin
                    load_wr   = 1'b1;
                    cnt_nxt   = CNT_INIT;
                    state_nxt = WR_WAIT;
                end else if (bus.ReadEnable) begin
                    load_rd   = 1'b1;
                    cnt_nxt   = CNT_INIT;
                    state_nxt = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (cnt == '0) begin
                    rd_fire   = 1'b1;
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            WR_WAIT: begin
                if (cnt == '0) begin
                    wr_fire   = 1'b1;
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_addr     <= '0;
            req_data     <= '0;
            bus.ready    <= 1'b0;
            bus.rd_block <= '0;
        end else begin
            if (load_wr) begin
                req_addr <= bus.addr;
                req_data <= bus.wr_data;
            end else if (load_rd) begin
                req_addr <= bus.addr & ~OFF_MASK;
            end
            bus.ready <= rd_fire | wr_fire;
            if (rd_fire) begin
                bus.rd_block <= arr_block;
            end
        end
    end

    assign bus.busy = (state != IDLE);

`ifdef MEM_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.rd_count <= '0;
            bus.wr_count <= '0;
        end else begin
            if (rd_fire && (bus.rd_count != '1)) begin
                bus.rd_count <= bus.rd_count + STAT_W'(1);
            end
            if (wr_fire && (bus.wr_count != '1)) begin
                bus.wr_count <= bus.wr_count + STAT_W'(1);
            end
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif
endmodule
